// File: rtl/saf_mon_pkg.sv
// rtl/saf_mon_pkg.sv - shared types and constants for the SAF MSE monitor
// Purpose: FSM state encodings, squared-sample width helper and the
//          completed-window counter width used by saf_mse_monitor and
//          saf_sq_accum.
// Ports:   none (package).
package saf_mon_pkg;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_TRACK  = 2'd1,
      ST_CONV   = 2'd2,
      ST_DIV    = 2'd3
   } mon_state_e;

   localparam int WIN_CNT_W = 16;

   // Width of a rounded, rescaled square: a Q.QP value squared is Q.2QP,
   // dropping QP fraction bits leaves 2*WIDTH-QP bits, enough for
   // (-2**(WIDTH-1))**2.
   function automatic int sq_w(input int width, input int qp);
      return 2 * width - qp;
   endfunction

endpackage

// File: rtl/saf_sq_accum.sv
// rtl/saf_sq_accum.sv - square-and-accumulate pipeline for windowed MSE
// Purpose: stage 1 squares each accepted error sample (rounded back to QP
//          fraction bits); stage 2 sums 2**LOG_WIN squares and presents the
//          saturated window mean together with a window-close strobe.
// Ports:   clk, reset      - clock, synchronous active-high reset
//          clear_i         - synchronous restart, same effect as reset
//          err_valid_i     - sample qualifier
//          err_in_i        - signed error sample Q(WIDTH-QP).QP
//          close_o         - high in the cycle whose edge closes a window
//          mean_o          - saturated window mean, valid while close_o
module saf_sq_accum
   import saf_mon_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int QP      = 12,
   parameter int LOG_WIN = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             err_valid_i,
   input  logic [WIDTH-1:0] err_in_i,
   output logic             close_o,
   output logic [WIDTH-1:0] mean_o
);

   localparam int SQ_W  = sq_w(WIDTH, QP);
   localparam int ACC_W = SQ_W + LOG_WIN;
   localparam int PW    = 2 * WIDTH;
   localparam logic [PW-1:0]   ROUND    = PW'(1) << (QP - 1);
   localparam logic [SQ_W-1:0] MAX_MEAN = SQ_W'((2 ** WIDTH) - 1);

   logic signed [PW-1:0] prod;
   logic [PW-1:0]        prod_rnd;
   logic [SQ_W-1:0]      sq_d, sq_q;
   logic                 sq_v_q;
   logic [LOG_WIN-1:0]   cnt_q;
   logic                 last_q;
   logic [ACC_W-1:0]     acc_q, sum;
   logic [SQ_W-1:0]      mean;

   always_comb begin
      prod     = $signed(err_in_i) * $signed(err_in_i);
      prod_rnd = $unsigned(prod) + ROUND;
      sq_d     = SQ_W'(prod_rnd >> QP);
      sum      = acc_q + ACC_W'(sq_q);
      mean     = SQ_W'(sum >> LOG_WIN);
      mean_o   = (mean > MAX_MEAN) ? '1 : mean[WIDTH-1:0];
      close_o  = sq_v_q & last_q;
   end

   // clear behaves exactly like reset, so a sample offered alongside clear
   // is dropped and the next window starts at sample 0.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         sq_q   <= '0;
         sq_v_q <= 1'b0;
         cnt_q  <= '0;
         last_q <= 1'b0;
         acc_q  <= '0;
      end else begin
         sq_v_q <= err_valid_i;
         if (err_valid_i) begin
            sq_q   <= sq_d;
            cnt_q  <= cnt_q + LOG_WIN'(1);
            last_q <= (cnt_q == '1);
         end
         if (sq_v_q) begin
            acc_q <= last_q ? '0 : sum;
         end
      end
   end

endmodule

// File: rtl/saf_mse_monitor.sv
// rtl/saf_mse_monitor.sv - windowed MSE monitor with convergence FSM
// Purpose: turns the adaptive filter's error stream into a windowed MSE
//          and classifies adaptation as warmup / track / converged /
//          diverged.
// Ports:   clk, reset      - clock, synchronous active-high reset
//          clear           - synchronous restart of statistics and FSM
//          err_valid       - error sample qualifier
//          err_in          - signed error sample
//          conv_thresh     - unsigned MSE convergence threshold (static)
//          div_thresh      - unsigned MSE divergence threshold (static)
//          mse_out         - saturated windowed MSE
//          mse_valid       - one-cycle pulse when mse_out updates
//          win_cnt         - completed windows, saturating
//          state_out       - FSM state
//          converged       - high while converged
//          diverged        - high while diverged (sticky)
module saf_mse_monitor
   import saf_mon_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int QP         = 12,
   parameter int LOG_WIN    = 4,
   parameter int WARMUP_WIN = 1,
   parameter int CONV_CNT   = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 err_valid,
   input  logic [WIDTH-1:0]     err_in,
   input  logic [WIDTH-1:0]     conv_thresh,
   input  logic [WIDTH-1:0]     div_thresh,
   output logic [WIDTH-1:0]     mse_out,
   output logic                 mse_valid,
   output logic [WIN_CNT_W-1:0] win_cnt,
   output logic [1:0]           state_out,
   output logic                 converged,
   output logic                 diverged
);

   localparam mon_state_e RST_ST = (WARMUP_WIN == 0) ? ST_TRACK : ST_WARMUP;
   localparam int GC_W = $clog2(CONV_CNT + 2);

   mon_state_e           state_q, state_d;
   logic [GC_W-1:0]      good_q, good_d;
   logic [WIN_CNT_W-1:0] win_q, win_inc;
   logic [WIDTH-1:0]     mse_q;
   logic                 mse_valid_q, conv_q, div_q;
   logic                 close;
   logic [WIDTH-1:0]     mean;

   saf_sq_accum #(
      .WIDTH   (WIDTH),
      .QP      (QP),
      .LOG_WIN (LOG_WIN)
   ) u_sq_accum (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (clear),
      .err_valid_i (err_valid),
      .err_in_i    (err_in),
      .close_o     (close),
      .mean_o      (mean)
   );

   // The FSM only moves on window close; divergence is tested before
   // convergence so a mean above both thresholds always lands in DIV.
   always_comb begin
      win_inc = (win_q == '1) ? win_q : win_q + WIN_CNT_W'(1);
      state_d = state_q;
      good_d  = good_q;
      if (close) begin
         case (state_q)
            ST_WARMUP: begin
               if (win_inc >= WIN_CNT_W'(WARMUP_WIN)) state_d = ST_TRACK;
            end
            ST_TRACK: begin
               if (mean >= div_thresh) begin
                  state_d = ST_DIV;
               end else if (mean < conv_thresh) begin
                  good_d = good_q + GC_W'(1);
                  if (good_d >= GC_W'(CONV_CNT)) state_d = ST_CONV;
               end else begin
                  good_d = '0;
               end
            end
            ST_CONV: begin
               if (mean >= div_thresh) begin
                  state_d = ST_DIV;
               end else if (mean >= conv_thresh) begin
                  state_d = ST_TRACK;
                  good_d  = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q     <= RST_ST;
         good_q      <= '0;
         win_q       <= '0;
         mse_q       <= '0;
         mse_valid_q <= 1'b0;
         conv_q      <= 1'b0;
         div_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         good_q      <= good_d;
         mse_valid_q <= close;
         if (close) begin
            mse_q  <= mean;
            win_q  <= win_inc;
            conv_q <= (state_d == ST_CONV);
            div_q  <= (state_d == ST_DIV);
         end
      end
   end

   assign mse_out   = mse_q;
   assign mse_valid = mse_valid_q;
   assign win_cnt   = win_q;
   assign state_out = state_q;
   assign converged = conv_q;
   assign diverged  = div_q;

endmodule
